// File: rtl/ncpu32k_issue_pkg.sv
// Shared configuration for the ncpu32k operand-issue slice: register-file geometry,
// data width, micro-op payload width and the hazard bundle type.
package ncpu32k_issue_pkg;

  localparam int NCPU_REG_AW = 5;
  localparam int NCPU_DW     = 32;
  localparam int NCPU_UOP_W  = 16;

  typedef struct packed {
    logic raw1;
    logic raw2;
    logic waw;
  } hazard_t;

endpackage

// File: rtl/ncpu32k_issue_if.sv
// Bundle of decoder, regfile-read, execute and writeback signals around the issue stage.
// slave = the issue stage itself, master = the surrounding pipeline.
interface ncpu32k_issue_if
  import ncpu32k_issue_pkg::*;
#(
  parameter int AW    = NCPU_REG_AW,
  parameter int DW    = NCPU_DW,
  parameter int UOP_W = NCPU_UOP_W
) ();

  logic             idu_valid;
  logic             idu_ready;
  logic [UOP_W-1:0] idu_uop;
  logic [AW-1:0]    idu_rs1_addr;
  logic [AW-1:0]    idu_rs2_addr;
  logic             idu_rs1_re;
  logic             idu_rs2_re;
  logic [AW-1:0]    idu_rd_addr;
  logic             idu_rd_we;

  logic [AW-1:0]    regf_rs1_addr;
  logic [AW-1:0]    regf_rs2_addr;
  logic             regf_rs1_re;
  logic             regf_rs2_re;
  logic [DW-1:0]    regf_rs1_dout;
  logic [DW-1:0]    regf_rs2_dout;

  logic             exu_valid;
  logic             exu_ready;
  logic [UOP_W-1:0] exu_uop;
  logic [DW-1:0]    exu_rs1;
  logic [DW-1:0]    exu_rs2;
  logic [AW-1:0]    exu_rd_addr;
  logic             exu_rd_we;

  logic             wb_we;
  logic [AW-1:0]    wb_addr;

  modport slave (
    input  idu_valid, idu_uop, idu_rs1_addr, idu_rs2_addr, idu_rs1_re, idu_rs2_re,
           idu_rd_addr, idu_rd_we, regf_rs1_dout, regf_rs2_dout, exu_ready, wb_we, wb_addr,
    output idu_ready, regf_rs1_addr, regf_rs2_addr, regf_rs1_re, regf_rs2_re,
           exu_valid, exu_uop, exu_rs1, exu_rs2, exu_rd_addr, exu_rd_we
  );

  modport master (
    output idu_valid, idu_uop, idu_rs1_addr, idu_rs2_addr, idu_rs1_re, idu_rs2_re,
           idu_rd_addr, idu_rd_we, regf_rs1_dout, regf_rs2_dout, exu_ready, wb_we, wb_addr,
    input  idu_ready, regf_rs1_addr, regf_rs2_addr, regf_rs1_re, regf_rs2_re,
           exu_valid, exu_uop, exu_rs1, exu_rs2, exu_rd_addr, exu_rd_we
  );

endinterface

// File: rtl/ncpu32k_scoreboard.sv
// Pending-write bit per architectural register; r0 never pends.
// Set beats clear on the same bit, flush clears everything.
module ncpu32k_scoreboard
  import ncpu32k_issue_pkg::*;
#(
  parameter int AW = NCPU_REG_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          set_i,
  input  logic [AW-1:0] set_addr_i,
  input  logic          clr_i,
  input  logic [AW-1:0] clr_addr_i,
  input  logic [AW-1:0] rs1_addr_i,
  input  logic [AW-1:0] rs2_addr_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic          rs1_pend_o,
  output logic          rs2_pend_o,
  output logic          rd_pend_o
);

  localparam int NREG = 1 << AW;

  logic [NREG-1:1] pending_q;
  logic [NREG-1:0] pending;

  assign pending = {pending_q, 1'b0};

  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_bit
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pending_q[gi] <= 1'b0;
        end else if (flush_i) begin
          pending_q[gi] <= 1'b0;
        end else if (set_i && (set_addr_i == AW'(gi))) begin
          pending_q[gi] <= 1'b1;
        end else if (clr_i && (clr_addr_i == AW'(gi))) begin
          pending_q[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign rs1_pend_o = pending[rs1_addr_i];
  assign rs2_pend_o = pending[rs2_addr_i];
  assign rd_pend_o  = pending[rd_addr_i];

endmodule

// File: rtl/ncpu32k_issue.sv
// Operand-issue stage: stalls on RAW/WAW against the pending scoreboard, reads the
// regfile on accept and holds one micro-op register toward execute.
module ncpu32k_issue
  import ncpu32k_issue_pkg::*;
#(
  parameter int AW    = NCPU_REG_AW,
  parameter int DW    = NCPU_DW,
  parameter int UOP_W = NCPU_UOP_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  ncpu32k_issue_if.slave  bus
);

  logic             rs1_pend;
  logic             rs2_pend;
  logic             rd_pend;
  hazard_t          hz;
  logic             free;
  logic             accept;

  logic             exu_valid_q, exu_valid_d;
  logic [UOP_W-1:0] exu_uop_q, exu_uop_d;
  logic [AW-1:0]    exu_rd_addr_q, exu_rd_addr_d;
  logic             exu_rd_we_q, exu_rd_we_d;

  ncpu32k_scoreboard #(.AW(AW)) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .set_i      (accept & bus.idu_rd_we & (bus.idu_rd_addr != '0)),
    .set_addr_i (bus.idu_rd_addr),
    .clr_i      (bus.wb_we),
    .clr_addr_i (bus.wb_addr),
    .rs1_addr_i (bus.idu_rs1_addr),
    .rs2_addr_i (bus.idu_rs2_addr),
    .rd_addr_i  (bus.idu_rd_addr),
    .rs1_pend_o (rs1_pend),
    .rs2_pend_o (rs2_pend),
    .rd_pend_o  (rd_pend)
  );

  // A same-cycle writeback releases the hazard: the regfile bypasses its data to the read.
  always_comb begin
    hz.raw1 = bus.idu_rs1_re & rs1_pend & ~(bus.wb_we & (bus.wb_addr == bus.idu_rs1_addr));
    hz.raw2 = bus.idu_rs2_re & rs2_pend & ~(bus.wb_we & (bus.wb_addr == bus.idu_rs2_addr));
    hz.waw  = bus.idu_rd_we  & rd_pend  & ~(bus.wb_we & (bus.wb_addr == bus.idu_rd_addr));
  end

  assign free          = ~exu_valid_q | bus.exu_ready;
  assign bus.idu_ready = free & ~(|hz) & ~flush;
  assign accept        = bus.idu_valid & bus.idu_ready;

  assign bus.regf_rs1_addr = bus.idu_rs1_addr;
  assign bus.regf_rs2_addr = bus.idu_rs2_addr;
  assign bus.regf_rs1_re   = accept & bus.idu_rs1_re;
  assign bus.regf_rs2_re   = accept & bus.idu_rs2_re;

  always_comb begin
    exu_valid_d   = exu_valid_q;
    exu_uop_d     = exu_uop_q;
    exu_rd_addr_d = exu_rd_addr_q;
    exu_rd_we_d   = exu_rd_we_q;
    if (flush) begin
      exu_valid_d = 1'b0;
    end else if (accept) begin
      exu_valid_d   = 1'b1;
      exu_uop_d     = bus.idu_uop;
      exu_rd_addr_d = bus.idu_rd_addr;
      exu_rd_we_d   = bus.idu_rd_we;
    end else if (exu_valid_q & bus.exu_ready) begin
      exu_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exu_valid_q   <= 1'b0;
      exu_uop_q     <= '0;
      exu_rd_addr_q <= '0;
      exu_rd_we_q   <= 1'b0;
    end else begin
      exu_valid_q   <= exu_valid_d;
      exu_uop_q     <= exu_uop_d;
      exu_rd_addr_q <= exu_rd_addr_d;
      exu_rd_we_q   <= exu_rd_we_d;
    end
  end

  // Operands come straight from the regfile, which holds its output while re is low.
  assign bus.exu_valid   = exu_valid_q;
  assign bus.exu_uop     = exu_uop_q;
  assign bus.exu_rd_addr = exu_rd_addr_q;
  assign bus.exu_rd_we   = exu_rd_we_q;
  assign bus.exu_rs1     = bus.regf_rs1_dout;
  assign bus.exu_rs2     = bus.regf_rs2_dout;

endmodule

// File: tb/tb_ncpu32k_issue.sv
// Randomized bench for ncpu32k_issue: regfile and writeback environment, a reference
// model of the issue rules, and a scoreboard monitor on the execute handshake.
module tb_ncpu32k_issue;
  import ncpu32k_issue_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int UW = 16;
  localparam int NCYC = 3000;
  localparam int RST_CYC = 1500;

  typedef struct {
    logic [UW-1:0] uop;
    logic [AW-1:0] rd;
    logic          we;
    logic          u1;
    logic [DW-1:0] v1;
    logic          u2;
    logic [DW-1:0] v2;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          rf_load;
  logic [DW-1:0] wb_data;

  always #5 clk = ~clk;

  ncpu32k_issue_if #(.AW(AW), .DW(DW), .UOP_W(UW)) bus ();

  ncpu32k_issue #(.AW(AW), .DW(DW), .UOP_W(UW)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 0) ? '0 : 32'h1000_0000 + 32'(i) * 32'h0101_0103;
  endfunction

  // Environment regfile: registered read with write bypass, output held while re is low.
  logic [DW-1:0] rf [32];
  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
    end else if (bus.wb_we && bus.wb_addr != 0) begin
      rf[bus.wb_addr] <= wb_data;
    end
    if (bus.regf_rs1_re)
      bus.regf_rs1_dout <= (bus.regf_rs1_addr == 0) ? '0 :
                           (bus.wb_we && bus.wb_addr == bus.regf_rs1_addr) ? wb_data : rf[bus.regf_rs1_addr];
    if (bus.regf_rs2_re)
      bus.regf_rs2_dout <= (bus.regf_rs2_addr == 0) ? '0 :
                           (bus.wb_we && bus.wb_addr == bus.regf_rs2_addr) ? wb_data : rf[bus.regf_rs2_addr];
  end

  int            tests = 0;
  int            fails = 0;
  int            n_acc = 0;
  int            n_cons = 0;
  exp_t          expq[$];
  logic [AW-1:0] wbq[$];
  bit            m_pend [32];
  bit            m_outv;
  logic [AW-1:0] m_out_rd;
  bit            m_out_we;
  logic [DW-1:0] ref_regs [32];
  bit            hold;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] opval(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (bus.wb_we && bus.wb_addr == a) return wb_data;
    return ref_regs[a];
  endfunction

  function automatic bit hazard(input logic use_it, input logic [AW-1:0] a);
    return use_it && m_pend[a] && !(bus.wb_we && bus.wb_addr == a);
  endfunction

  // Reference model step for the current cycle, evaluated mid-cycle on the driven inputs.
  task automatic model_step();
    bit   m_ready, m_acc, cons;
    exp_t e;
    m_ready = (!m_outv || bus.exu_ready) && !flush
              && !hazard(bus.idu_rs1_re, bus.idu_rs1_addr)
              && !hazard(bus.idu_rs2_re, bus.idu_rs2_addr)
              && !hazard(bus.idu_rd_we, bus.idu_rd_addr);
    m_acc = bus.idu_valid && m_ready;
    check("idu_ready", 32'(bus.idu_ready), 32'(m_ready));
    check("exu_valid", 32'(bus.exu_valid), 32'(m_outv));
    check("regf_rs1_re", 32'(bus.regf_rs1_re), 32'(m_acc && bus.idu_rs1_re));
    check("regf_rs2_re", 32'(bus.regf_rs2_re), 32'(m_acc && bus.idu_rs2_re));
    hold = bus.idu_valid && !m_acc;
    if (flush) begin
      m_outv = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
      expq.delete();
      return;
    end
    cons = m_outv && bus.exu_ready;
    if (cons) begin
      n_cons++;
      if (m_out_we && m_out_rd != 0) wbq.push_back(m_out_rd);
    end
    if (m_acc) begin
      n_acc++;
      e.uop = bus.idu_uop;  e.rd = bus.idu_rd_addr;  e.we = bus.idu_rd_we;
      e.u1 = bus.idu_rs1_re; e.v1 = opval(bus.idu_rs1_addr);
      e.u2 = bus.idu_rs2_re; e.v2 = opval(bus.idu_rs2_addr);
      expq.push_back(e);
    end
    if (bus.wb_we) begin
      ref_regs[bus.wb_addr] = wb_data;
      m_pend[bus.wb_addr] = 0;
    end
    if (m_acc) begin
      m_outv = 1;
      m_out_rd = bus.idu_rd_addr;
      m_out_we = bus.idu_rd_we;
      if (bus.idu_rd_we && bus.idu_rd_addr != 0) m_pend[bus.idu_rd_addr] = 1;
    end else if (cons) begin
      m_outv = 0;
    end
  endtask

  task automatic clear_model();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_outv = 0;
    hold = 0;
    expq.delete();
    wbq.delete();
  endtask

  // Monitor: compares every execute handshake against the oldest expected micro-op.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && bus.exu_valid && bus.exu_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_exu_valid", 32'(bus.exu_valid), 32'd0);
        end else begin
          e = expq.pop_front();
          check("exu_uop", 32'(bus.exu_uop), 32'(e.uop));
          check("exu_rd_addr", 32'(bus.exu_rd_addr), 32'(e.rd));
          check("exu_rd_we", 32'(bus.exu_rd_we), 32'(e.we));
          if (e.u1) check("exu_rs1", bus.exu_rs1, e.v1);
          if (e.u2) check("exu_rs2", bus.exu_rs2, e.v2);
        end
      end
    end
  end

  // Driver: decoder, execute backpressure, writeback and flush stimulus.
  initial begin
    rst = 1'b1; rf_load = 1'b1; flush = 1'b0; wb_data = '0;
    bus.idu_valid = 0; bus.idu_uop = '0; bus.idu_rs1_addr = '0; bus.idu_rs2_addr = '0;
    bus.idu_rs1_re = 0; bus.idu_rs2_re = 0; bus.idu_rd_addr = '0; bus.idu_rd_we = 0;
    bus.exu_ready = 0; bus.wb_we = 0; bus.wb_addr = '0;
    for (int i = 0; i < 32; i++) ref_regs[i] = init_val(i);
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_exu_valid", 32'(bus.exu_valid), 32'd0);
    check("rst_exu_uop", 32'(bus.exu_uop), 32'd0);
    check("rst_exu_rd_addr", 32'(bus.exu_rd_addr), 32'd0);
    check("rst_exu_rd_we", 32'(bus.exu_rd_we), 32'd0);
    check("rst_idu_ready", 32'(bus.idu_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0; rf_load = 1'b0;

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      if (c == RST_CYC) begin
        bus.idu_valid = 0; bus.wb_we = 0; bus.exu_ready = 0; flush = 0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_exu_valid", 32'(bus.exu_valid), 32'd0);
        check("async_rst_exu_rd_we", 32'(bus.exu_rd_we), 32'd0);
        clear_model();
        @(posedge clk);
        #1 rst = 1'b0;
        continue;
      end
      if (!hold) begin
        bus.idu_valid    = ($urandom_range(3) != 0);
        bus.idu_uop      = UW'($urandom);
        bus.idu_rs1_addr = AW'($urandom_range(7));
        bus.idu_rs2_addr = AW'($urandom_range(7));
        bus.idu_rs1_re   = 1'($urandom_range(1));
        bus.idu_rs2_re   = 1'($urandom_range(1));
        bus.idu_rd_addr  = AW'($urandom_range(7));
        bus.idu_rd_we    = ($urandom_range(3) != 0);
      end
      if (wbq.size() > 0 && $urandom_range(1) == 1) begin
        bus.wb_we = 1; bus.wb_addr = wbq.pop_front(); wb_data = $urandom;
      end else begin
        bus.wb_we = 0;
      end
      flush = (wbq.size() == 0 && !bus.wb_we && $urandom_range(29) == 0);
      bus.exu_ready = !flush && ($urandom_range(9) < 7);
      @(negedge clk);
      model_step();
    end

    tests++;
    if (n_cons < 200) begin
      fails++;
      $display("FAIL progress: got %0d consumed micro-ops required at least 200", n_cons);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ncpu32k_issue.md
# ncpu32k_issue

Operand-issue stage between the instruction decoder and the execute stage. It drives the read ports of `ncpu32k_regfile`, keeps a pending-write scoreboard to stall on RAW/WAW hazards, and presents each micro-op to execute together with its two operands. It uses a valid/ready handshake on both sides, sustains one micro-op per cycle, and has one cycle of latency.

## Interface
Parameters:
- AW, 5, register address width (`NCPU_REG_AW`)
- DW, 32, data width (`NCPU_DW`)
- UOP_W, 16, opaque micro-op payload width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  kill in-flight issue and clear scoreboard
- idu_valid  in  1  decoder offers a micro-op
- idu_ready  out  1  stage accepts this cycle
- idu_uop  in  UOP_W  micro-op payload
- idu_rs1_addr / idu_rs2_addr  in  AW  source addresses
- idu_rs1_re / idu_rs2_re  in  1  source used
- idu_rd_addr  in  AW  destination address
- idu_rd_we  in  1  destination written
- regf_rs1_addr / regf_rs2_addr  out  AW  regfile read addresses
- regf_rs1_re / regf_rs2_re  out  1  regfile read enables
- regf_rs1_dout / regf_rs2_dout  in  DW  regfile read data, valid the cycle after re; held while re is low
- exu_valid  out  1  micro-op presented to execute
- exu_ready  in  1  execute accepts
- exu_uop  out  UOP_W  registered payload
- exu_rs1 / exu_rs2  out  DW  operands (regf dout passthrough)
- exu_rd_addr  out  AW  registered destination
- exu_rd_we  out  1  registered destination enable
- wb_we  in  1  writeback to regfile this cycle
- wb_addr  in  AW  writeback address

## Operation
- Scoreboard: `pending[2^AW-1:0]`, one bit per register. Bit 0 is constant 0.
- `wb_hit(a)` = wb_we & (wb_addr==a). Regfile write bypass makes same-cycle writeback data visible to a read.
- Hazards:
  - raw1 = idu_rs1_re & pending[rs1] & ~wb_hit(rs1); raw2 is analogous.
  - waw = idu_rd_we & pending[rd] & ~wb_hit(rd).
- `free` = ~exu_valid | exu_ready.
- `idu_ready` = free & ~raw1 & ~raw2 & ~waw & ~flush. It is combinational and may depend on the idu_* address inputs.
- `accept` = idu_valid & idu_ready.
- Regfile ports:
  - regf_rsN_addr = idu_rsN_addr.
  - regf_rsN_re = accept & idu_rsN_re.
  - With re low, regfile dout holds, so operands remain stable while execute stalls.
- On accept:
  - exu_uop, exu_rd_addr and exu_rd_we are loaded.
  - exu_valid is set to 1.
  - If idu_rd_we & rd≠0, pending[rd] is set.
- Otherwise, if exu_valid & exu_ready, exu_valid is cleared to 0.
- wb_we clears pending[wb_addr]. If a set and a clear of the same bit occur in the same cycle, the set wins.
- Unused sources: an operand whose re was 0 is don't-care on exu_rsN.
- flush:
  - Takes priority over everything.
  - exu_valid←0 and pending←0; the accept is blocked.
  - wb_we in the same cycle is ignored.
  - Upstream issues flush only once no older writeback remains outstanding.

## Timing
- Reset: exu_valid=0, pending=0, exu_uop=0, exu_rd_addr=0, exu_rd_we=0. idu_ready follows its equation; it is 1 after reset unless flush is asserted.
- Latency: accept in cycle N → exu_valid=1 with valid operands in cycle N+1.
- Throughput: one per cycle while exu_ready=1 and no hazard.
- Back-to-back dependency: a consumer of rd stalls until the cycle wb_hit(rd) is asserted. It is accepted in that cycle.
- Handshake: exu_* outputs are stable while exu_valid & ~exu_ready. The decoder must hold idu_* stable while idu_valid & ~idu_ready.
- Reset mid-operation clears all state asynchronously. No partial pending bits survive.

## Structure
- Shared package/header `ncpu32k_config.h` holds `NCPU_REG_AW` and `NCPU_DW`. The UOP_W constant goes there as `NCPU_UOP_W`.
- One sub-module, `ncpu32k_scoreboard`, holds the pending bit vector with set/clear/flush and two read ports plus a destination-check port. The issue top holds hazard logic and the output register.
- Regfile is instantiated outside this block, at the same level.

## Test plan
- Independent stream: 4 ops, rs1=1, rs2=2, rd=3..6, exu_ready=1 → exu_valid in cycles N+1..N+4; operands equal reg contents.
- RAW stall: op A rd=5 accepted, then op B rs1=5. B is held with idu_ready=0 until wb_we=1, wb_addr=5, data 0xDEADBEEF. B is accepted that cycle and exu_rs1=0xDEADBEEF next cycle.
- Backpressure: exu_ready=0 for 3 cycles with exu_valid=1 → exu_uop/exu_rs1/exu_rs2 are unchanged, idu_ready=0, and no regf re pulses.
- r0: op rd=0 then op rs1=0 → no stall, pending[0] stays 0.
- Simultaneous set/clear: wb clears rd=7 while a new op with rd=7 is accepted → pending[7]=1 afterwards; a later rs1=7 stalls.
- Flush and reset: flush with pending[3]=1 and exu_valid=1 → both 0 next cycle. Async rst mid-stall → exu_valid=0 immediately.
